om_range_arbiter: RTL and testbench
===================================

Name: om_range_arbiter

Overview:
- Shares the overflow-range buffer's single write port between two producers: the heap store-overflow tracker (src 0) and the dataleak consecutive-load tracker (src 1).
- Queues detected ranges in a small FIFO and arbitrates round-robin between producers.
- Drops malformed and duplicate ranges, sequences buffer clear requests, and exposes statistics counters.
- Sits between the two trackers and the range buffer, inside the execute-stage security unit.

Parameters:
- FIFO_DEPTH, 4, pending-range entries; power of 2, minimum 2.
- CLEAR_CYCLES, 2, number of cycles buf_clear_o is held high per clear.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- heap_valid_i  in  1  heap tracker has a range
- heap_first_i  in  32  heap range first address
- heap_last_i  in  32  heap range last address
- heap_ready_o  out  1  heap range accepted this cycle
- dlk_valid_i  in  1  dataleak tracker has a range
- dlk_first_i  in  32  dataleak range first address
- dlk_last_i  in  32  dataleak range last address
- dlk_ready_o  out  1  dataleak range accepted this cycle
- clear_i  in  1  flush request (buffer reset from CSR)
- buf_wr_en_o  out  1  write strobe to the range buffer
- buf_first_o  out  32  range first address to write
- buf_last_o  out  32  range last address to write
- buf_src_o  out  1  source id of the written range
- buf_wr_ready_i  in  1  range buffer accepts the write
- buf_clear_o  out  1  clears the range buffer
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries
- written_cnt_o  out  CNT_W  ranges committed to the buffer
- drop_cnt_o  out  CNT_W  ranges dropped as malformed or duplicate
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - State IDLE, FIFO empty, rr_q=0 (heap preferred), duplicate register invalid, counters 0.
  - Every output is 0 except fifo_level_o=0.
- States:
  - IDLE: FIFO empty.
  - DRAIN: FIFO non-empty.
  - CLEAR: flushing.
  - IDLE->DRAIN on a push. DRAIN->IDLE when the last entry pops with no push in the same cycle. Any state->CLEAR when clear_i=1. CLEAR->IDLE after CLEAR_CYCLES cycles with clear_i low.
- Arbitration:
  - Readies depend combinationally on valids, clear_i, state and the full flag. At most one grant per cycle.
  - Grants happen only when state != CLEAR, clear_i=0 and FIFO not full.
  - If both producers are valid, grant the source equal to rr_q. If one is valid, grant it.
  - After any grant, rr_q becomes the non-granted source.
  - ready_o is high only for the granted source. A producer holds valid and data until it sees ready.
- Filtering, applied to the granted range:
  - If first > last (unsigned), the range is accepted but not pushed; drop_cnt++.
  - If the duplicate register is valid and {first,last} equals it, the range is accepted but not pushed; drop_cnt++.
  - Otherwise the range is pushed as {first,last,src}, and the duplicate register is loaded with {first,last}.
  - first == last is legal (single byte).
- Drain:
  - buf_wr_en_o = (state==DRAIN) & !clear_i. buf_first_o, buf_last_o and buf_src_o carry the FIFO head.
  - Pop when buf_wr_en_o & buf_wr_ready_i; written_cnt++ on each pop.
  - Minimum latency: a range accepted in cycle N appears on buf_wr_en_o in cycle N+1.
  - When buf_wr_ready_i is low, the head is held stable.
- Full/empty:
  - Push and pop in the same cycle are both legal when not full; level is unchanged.
  - When full, no grant occurs even if a pop happens that cycle (no bypass).
  - An empty FIFO never produces a write.
- Clear:
  - While in CLEAR, and in the cycle clear_i is raised: readies low, buf_wr_en_o low, FIFO flushed, duplicate register invalidated.
  - buf_clear_o is high throughout CLEAR, for exactly CLEAR_CYCLES cycles after clear_i falls. If clear_i re-asserts during CLEAR, the count restarts.
  - Counters are not cleared by clear_i.
- Counters saturate at all-ones. Pointer wrap-around is modulo FIFO_DEPTH.
- Reset asserted mid-drain or mid-clear has immediate effect at the next edge; no partial write is completed.

Decomposition:
- Shared package om_pkg holds:
  - om_range_t struct {first[31:0], last[31:0], src}.
  - om_src_e {OM_SRC_HEAP=0, OM_SRC_DLK=1}.
  - om_arb_state_e {IDLE, DRAIN, CLEAR}.
  - Constant OM_ADDR_W=32.
- Sub-module om_range_fifo: synchronous FIFO of om_range_t with push/pop/flush, full/empty/level outputs and sync active-high reset.

Test Plan:
- Heap only: heap valid, first=0x1000, last=0x1040, buf_wr_ready_i=1 -> heap_ready_o=1 in cycle N; buf_wr_en_o=1 with those values and src=0 in cycle N+1; written_cnt_o=1.
- Both valid for 4 cycles with distinct ranges, starting after reset -> grants alternate heap, dlk, heap, dlk; FIFO contents emerge in that order.
- Malformed and duplicate: push first=0x2000, last=0x1FFF -> accepted, nothing written, drop_cnt_o=1. Push 0x3000..0x3010 twice -> one write, drop_cnt_o=2.
- Backpressure: buf_wr_ready_i=0, 6 ranges offered -> 4 accepted, fifo_level_o=4, readies low while full. Raise buf_wr_ready_i -> 4 writes on consecutive cycles.
- Clear with FIFO holding 3 entries -> clear_i=1 for 1 cycle: buf_wr_en_o=0 and readies low immediately; FIFO flushed (fifo_level_o=0); buf_clear_o high for 2 cycles after clear_i falls; then IDLE; counters unchanged.
- rst_i pulsed while in DRAIN with a stalled write -> next cycle all outputs 0, fifo_level_o=0, busy_o=0.

Source files
------------

// File: rtl/om_pkg.sv
// Shared types for the overflow-range arbiter: range payload, source ids and arbiter states.
package om_pkg;

    localparam int OM_ADDR_W = 32;

    typedef enum logic {
        OM_SRC_HEAP = 1'b0,
        OM_SRC_DLK  = 1'b1
    } om_src_e;

    typedef struct packed {
        logic [OM_ADDR_W-1:0] first;
        logic [OM_ADDR_W-1:0] last;
        om_src_e              src;
    } om_range_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } om_arb_state_e;

    function automatic logic om_range_malformed(input om_range_t r);
        return r.first > r.last;
    endfunction

endpackage

// File: rtl/om_range_fifo.sv
// Pending-range FIFO: head visible the cycle after a push, push ignored when full, pop ignored when empty.
// flush_i empties the queue at the next edge and takes priority over a same-cycle push.
module om_range_fifo
    import om_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  om_range_t              push_data_i,
    input  logic                   pop_i,
    output om_range_t              head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    om_range_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + (PTR_W+1)'(1);
                2'b01:   level_q <= level_q - (PTR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i && !rst_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/om_range_arbiter.sv
// Round-robin merge of heap/dataleak ranges into the range buffer; accepted range written 1 cycle later.
// Producers stall (ready low) while the FIFO is full or a clear is in progress; buffer stall holds the head.
module om_range_arbiter
    import om_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          heap_valid_i,
    input  logic [OM_ADDR_W-1:0]          heap_first_i,
    input  logic [OM_ADDR_W-1:0]          heap_last_i,
    output logic                          heap_ready_o,
    input  logic                          dlk_valid_i,
    input  logic [OM_ADDR_W-1:0]          dlk_first_i,
    input  logic [OM_ADDR_W-1:0]          dlk_last_i,
    output logic                          dlk_ready_o,
    input  logic                          clear_i,
    output logic                          buf_wr_en_o,
    output logic [OM_ADDR_W-1:0]          buf_first_o,
    output logic [OM_ADDR_W-1:0]          buf_last_o,
    output logic                          buf_src_o,
    input  logic                          buf_wr_ready_i,
    output logic                          buf_clear_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [CNT_W-1:0]              written_cnt_o,
    output logic [CNT_W-1:0]              drop_cnt_o,
    output logic                          busy_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    om_arb_state_e              state_q, state_d;
    om_src_e                    rr_q;
    logic                       dup_vld_q;
    logic [2*OM_ADDR_W-1:0]     dup_q;
    logic [CLR_W-1:0]           clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]           written_q, drop_q;

    om_range_t                  cand;
    om_range_t                  fifo_head;
    logic                       fifo_full, fifo_empty;
    logic [LVL_W-1:0]           fifo_level;
    logic                       flush;
    logic                       can_grant, heap_gnt, dlk_gnt, any_gnt;
    logic                       dup_hit, bad_range, push, drop;
    logic                       wr_en, pop;

    assign flush     = clear_i | (state_q == CLEAR);
    assign can_grant = (state_q != CLEAR) & ~clear_i & ~fifo_full;
    assign heap_gnt  = can_grant & heap_valid_i & (~dlk_valid_i | (rr_q == OM_SRC_HEAP));
    assign dlk_gnt   = can_grant & dlk_valid_i & (~heap_valid_i | (rr_q == OM_SRC_DLK));
    assign any_gnt   = heap_gnt | dlk_gnt;

    always_comb begin
        cand = '{first: heap_first_i, last: heap_last_i, src: OM_SRC_HEAP};
        if (dlk_gnt) cand = '{first: dlk_first_i, last: dlk_last_i, src: OM_SRC_DLK};
    end

    assign bad_range = om_range_malformed(cand);
    assign dup_hit   = dup_vld_q & ({cand.first, cand.last} == dup_q);
    assign push      = any_gnt & ~bad_range & ~dup_hit;
    assign drop      = any_gnt & (bad_range | dup_hit);

    // State tracks occupancy, so DRAIN alone qualifies the write strobe.
    assign wr_en = (state_q == DRAIN) & ~clear_i;
    assign pop   = wr_en & buf_wr_ready_i;

    om_range_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (cand),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE:  if (push) state_d = DRAIN;
            DRAIN: if (pop && !push && fifo_level == LVL_W'(1)) state_d = IDLE;
            CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            rr_q      <= OM_SRC_HEAP;
            dup_vld_q <= 1'b0;
            dup_q     <= '0;
            written_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if (heap_gnt) rr_q <= OM_SRC_DLK;
            if (dlk_gnt)  rr_q <= OM_SRC_HEAP;
            if (flush) begin
                dup_vld_q <= 1'b0;
            end else if (push) begin
                dup_vld_q <= 1'b1;
                dup_q     <= {cand.first, cand.last};
            end
            if (pop && !(&written_q)) written_q <= written_q + CNT_W'(1);
            if (drop && !(&drop_q))   drop_q    <= drop_q + CNT_W'(1);
        end
    end

    assign heap_ready_o  = heap_gnt;
    assign dlk_ready_o   = dlk_gnt;
    assign buf_wr_en_o   = wr_en;
    // Stale storage is masked so the buffer port reads zero whenever nothing is queued.
    assign buf_first_o   = fifo_empty ? '0 : fifo_head.first;
    assign buf_last_o    = fifo_empty ? '0 : fifo_head.last;
    assign buf_src_o     = fifo_empty ? 1'b0 : fifo_head.src;
    assign buf_clear_o   = (state_q == CLEAR);
    assign fifo_level_o  = fifo_level;
    assign written_cnt_o = written_q;
    assign drop_cnt_o    = drop_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_om_range_arbiter.sv
// Scoreboard bench for om_range_arbiter: per-cycle reference model at negedge, directed scenarios in the initial block.
module tb_om_range_arbiter;

    localparam int DEPTH = 4;
    localparam int CLR_N = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        heap_valid_i, dlk_valid_i;
    logic [31:0] heap_first_i, heap_last_i, dlk_first_i, dlk_last_i;
    logic        heap_ready_o, dlk_ready_o;
    logic        clear_i;
    logic        buf_wr_en_o, buf_src_o, buf_wr_ready_i, buf_clear_o;
    logic [31:0] buf_first_o, buf_last_o;
    logic [2:0]  fifo_level_o;
    logic [15:0] written_cnt_o, drop_cnt_o;
    logic        busy_o;

    om_range_arbiter #(.FIFO_DEPTH(DEPTH), .CLEAR_CYCLES(CLR_N), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .heap_valid_i(heap_valid_i), .heap_first_i(heap_first_i), .heap_last_i(heap_last_i),
        .heap_ready_o(heap_ready_o),
        .dlk_valid_i(dlk_valid_i), .dlk_first_i(dlk_first_i), .dlk_last_i(dlk_last_i),
        .dlk_ready_o(dlk_ready_o),
        .clear_i(clear_i),
        .buf_wr_en_o(buf_wr_en_o), .buf_first_o(buf_first_o), .buf_last_o(buf_last_o),
        .buf_src_o(buf_src_o), .buf_wr_ready_i(buf_wr_ready_i), .buf_clear_o(buf_clear_o),
        .fifo_level_o(fifo_level_o), .written_cnt_o(written_cnt_o), .drop_cnt_o(drop_cnt_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Producer queues, scoreboard of expected buffer writes ({first,last,src}), observed grant order.
    logic [63:0] hp_q[$];
    logic [63:0] dl_q[$];
    logic [64:0] sb[$];
    bit          gnt_log[$];

    // Reference model state.
    bit          m_rr, m_clear, m_dup_vld;
    int          m_ccnt, m_written, m_drop;
    logic [63:0] m_dup;
    bit          eh, ed, exp_wr;
    logic [31:0] mf, ml;
    bit          ms;
    logic [63:0] tmp64;
    logic [64:0] tmp65;

    // Producers hold valid/data until the model sees the grant and retires the entry.
    always @(posedge clk) begin
        #1;
        heap_valid_i = (hp_q.size() != 0);
        dlk_valid_i  = (dl_q.size() != 0);
        if (hp_q.size() != 0) {heap_first_i, heap_last_i} = hp_q[0];
        if (dl_q.size() != 0) {dlk_first_i, dlk_last_i} = dl_q[0];
    end

    always @(negedge clk) begin
        if (rst_i) begin
            sb.delete();
            m_rr = 0; m_clear = 0; m_ccnt = 0; m_dup_vld = 0; m_dup = '0;
            m_written = 0; m_drop = 0;
        end else begin
            exp_wr = !m_clear && (sb.size() != 0) && !clear_i;
            eh = !m_clear && !clear_i && (sb.size() < DEPTH) && heap_valid_i && (!dlk_valid_i || !m_rr);
            ed = !m_clear && !clear_i && (sb.size() < DEPTH) && dlk_valid_i && (!heap_valid_i || m_rr);
            check_val("busy", 64'(busy_o), 64'(m_clear || sb.size() != 0));
            check_val("wr_en", 64'(buf_wr_en_o), 64'(exp_wr));
            check_val("buf_clear", 64'(buf_clear_o), 64'(m_clear));
            check_val("heap_rdy", 64'(heap_ready_o), 64'(eh));
            check_val("dlk_rdy", 64'(dlk_ready_o), 64'(ed));
            check_val("level", 64'(fifo_level_o), 64'(sb.size()));
            check_val("written", 64'(written_cnt_o), 64'(m_written));
            check_val("drops", 64'(drop_cnt_o), 64'(m_drop));
            if (heap_ready_o) gnt_log.push_back(1'b0);
            if (dlk_ready_o)  gnt_log.push_back(1'b1);
            if (sb.size() == 0)
                check_val("idle_data", 64'({buf_first_o, buf_last_o} | 64'(buf_src_o)), 64'd0);
            if (exp_wr) begin
                check_val("head_first", 64'(buf_first_o), 64'(sb[0][64:33]));
                check_val("head_last", 64'(buf_last_o), 64'(sb[0][32:1]));
                check_val("head_src", 64'(buf_src_o), 64'(sb[0][0]));
                if (buf_wr_ready_i) begin
                    tmp65 = sb.pop_front();
                    m_written++;
                end
            end
            if (eh || ed) begin
                if (eh) begin
                    {mf, ml} = {heap_first_i, heap_last_i}; ms = 0; tmp64 = hp_q.pop_front();
                end else begin
                    {mf, ml} = {dlk_first_i, dlk_last_i}; ms = 1; tmp64 = dl_q.pop_front();
                end
                m_rr = !ms;
                if (mf > ml || (m_dup_vld && {mf, ml} == m_dup)) begin
                    m_drop++;
                end else begin
                    sb.push_back({mf, ml, ms});
                    m_dup_vld = 1; m_dup = {mf, ml};
                end
            end
            if (clear_i) begin
                sb.delete(); m_dup_vld = 0; m_clear = 1; m_ccnt = 0;
            end else if (m_clear) begin
                if (m_ccnt == CLR_N - 1) m_clear = 0;
                else m_ccnt++;
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_i = 1;
        to_drive();
        rst_i = 0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((hp_q.size() != 0 || dl_q.size() != 0 || sb.size() != 0 || m_clear) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        if (n >= max_cyc) check_val("drain_timeout", 64'(n), 64'(max_cyc - 1));
        to_drive();
    endtask

    int save_wr, save_dr;

    initial begin
        rst_i = 1; clear_i = 0; buf_wr_ready_i = 1;
        heap_valid_i = 0; dlk_valid_i = 0;
        heap_first_i = '0; heap_last_i = '0; dlk_first_i = '0; dlk_last_i = '0;
        repeat (3) to_drive();
        rst_i = 0;
        @(negedge clk);
        check_val("rst_level", 64'(fifo_level_o), 64'd0);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        check_val("rst_wr_en", 64'(buf_wr_en_o), 64'd0);
        to_drive();

        // Single heap range.
        hp_q.push_back({32'h1000, 32'h1040});
        drain(20);
        check_val("t1_written", 64'(written_cnt_o), 64'd1);

        // Both producers valid from reset: heap, dlk, heap, dlk.
        pulse_reset();
        gnt_log.delete();
        hp_q.push_back({32'h100, 32'h1ff}); hp_q.push_back({32'h300, 32'h3ff});
        dl_q.push_back({32'h200, 32'h2ff}); dl_q.push_back({32'h400, 32'h4ff});
        drain(30);
        check_val("t2_gnt_cnt", 64'(gnt_log.size()), 64'd4);
        if (gnt_log.size() == 4)
            check_val("t2_gnt_order", 64'({gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}), 64'(4'b0101));
        check_val("t2_written", 64'(written_cnt_o), 64'd4);

        // Malformed, duplicate, then a single-byte range.
        pulse_reset();
        hp_q.push_back({32'h2000, 32'h1fff});
        hp_q.push_back({32'h3000, 32'h3010});
        hp_q.push_back({32'h3000, 32'h3010});
        drain(30);
        check_val("t3_drops", 64'(drop_cnt_o), 64'd2);
        check_val("t3_written", 64'(written_cnt_o), 64'd1);
        hp_q.push_back({32'h4000, 32'h4000});
        drain(20);
        check_val("t3_single", 64'(written_cnt_o), 64'd2);

        // Backpressure: six offered, four fit.
        pulse_reset();
        buf_wr_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            hp_q.push_back({32'h5000 + 32'(i * 16), 32'h5008 + 32'(i * 16)});
            dl_q.push_back({32'h6000 + 32'(i * 16), 32'h6008 + 32'(i * 16)});
        end
        repeat (10) to_drive();
        @(negedge clk);
        check_val("t4_full_level", 64'(fifo_level_o), 64'd4);
        check_val("t4_pending", 64'(hp_q.size() + dl_q.size()), 64'd2);
        check_val("t4_rdy_full", 64'(heap_ready_o | dlk_ready_o), 64'd0);
        to_drive();
        buf_wr_ready_i = 1;
        drain(40);
        check_val("t4_written", 64'(written_cnt_o), 64'd6);

        // Clear with three entries queued and a fourth range waiting.
        buf_wr_ready_i = 0;
        for (int i = 0; i < 3; i++) hp_q.push_back({32'h7000 + 32'(i * 256), 32'h7080 + 32'(i * 256)});
        repeat (6) to_drive();
        check_val("t5_level3", 64'(fifo_level_o), 64'd3);
        save_wr = int'(written_cnt_o);
        save_dr = int'(drop_cnt_o);
        clear_i = 1;
        hp_q.push_back({32'h9000, 32'h9100});
        @(negedge clk);
        check_val("t5_clr_wr_en", 64'(buf_wr_en_o), 64'd0);
        check_val("t5_clr_rdy", 64'(heap_ready_o | dlk_ready_o), 64'd0);
        to_drive();
        clear_i = 0;
        buf_wr_ready_i = 1;
        @(negedge clk);
        check_val("t5_bclr_1", 64'(buf_clear_o), 64'd1);
        check_val("t5_flushed", 64'(fifo_level_o), 64'd0);
        @(negedge clk);
        check_val("t5_bclr_2", 64'(buf_clear_o), 64'd1);
        @(negedge clk);
        check_val("t5_bclr_off", 64'(buf_clear_o), 64'd0);
        check_val("t5_idle", 64'(busy_o), 64'd0);
        check_val("t5_wr_keep", 64'(written_cnt_o), 64'(save_wr));
        check_val("t5_dr_keep", 64'(drop_cnt_o), 64'(save_dr));
        to_drive();
        drain(20);
        check_val("t5_after", 64'(written_cnt_o), 64'(save_wr + 1));

        // Reset during a stalled drain.
        buf_wr_ready_i = 0;
        hp_q.push_back({32'ha000, 32'ha0ff});
        dl_q.push_back({32'hb000, 32'hb0ff});
        repeat (5) to_drive();
        check_val("t6_busy", 64'(busy_o), 64'd1);
        pulse_reset();
        @(negedge clk);
        check_val("t6_wr_en", 64'(buf_wr_en_o), 64'd0);
        check_val("t6_data", 64'({buf_first_o, buf_last_o} | 64'(buf_src_o)), 64'd0);
        check_val("t6_level", 64'(fifo_level_o), 64'd0);
        check_val("t6_busy0", 64'(busy_o), 64'd0);
        check_val("t6_cnts", 64'({written_cnt_o, drop_cnt_o}), 64'd0);
        check_val("t6_misc", 64'({buf_clear_o, heap_ready_o, dlk_ready_o}), 64'd0);
        to_drive();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
